// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block: register indices, field layouts,
// exception codes and exception vectors.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] CP0_VEC_BEV1 = 32'hBFC0_0380;
    localparam logic [31:0] CP0_VEC_BEV0 = 32'h8000_0180;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcAdel = 5'd4,
        ExcAdes = 5'd5,
        ExcSys  = 5'd8,
        ExcBp   = 5'd9,
        ExcRi   = 5'd10,
        ExcOv   = 5'd12,
        ExcTr   = 5'd13
    } exc_code_e;

    typedef struct packed {
        logic [8:0] zero_31_23;
        logic       bev;
        logic [5:0] zero_21_16;
        logic [7:0] im;
        logic [5:0] zero_7_2;
        logic       exl;
        logic       ie;
    } cp0_status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_29_16;
        logic [7:0]  ip;
        logic        zero_7;
        logic [4:0]  exc_code;
        logic [1:0]  zero_1_0;
    } cp0_cause_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a match
// and is cleared only by a Compare write.
module cp0_timer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q + {31'b0, tick_q};
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (count_we_i) begin
            count_d = wdata_i;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0.sv
// Coprocessor-0 register file and exception controller: records exception state,
// produces exception/ERET redirects and the interrupt request.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] VEC_BEV1 = CP0_VEC_BEV1,
    parameter logic [31:0] VEC_BEV0 = CP0_VEC_BEV0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_en,
    input  logic        exp,
    input  logic [4:0]  excode,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        cp0_badwen,
    input  logic [31:0] cp0_badvaddr,
    input  logic        cp0_wen,
    input  logic [4:0]  cp0_regw,
    input  logic [31:0] cp0_wdata,
    input  logic        eret,
    input  logic [5:0]  ext_int,
    input  logic [4:0]  cp0_rreg,
    output logic [31:0] cp0_rdata,
    output logic        int_pending,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [7:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic        exc_en, eret_en, wr_en;
    logic [31:0] count, compare;
    logic        ti;
    cp0_status_t status_view;
    cp0_cause_t  cause_view;

    assign exc_en  = commit_en & exp;
    assign eret_en = commit_en & eret & ~exp;
    assign wr_en   = commit_en & cp0_wen & ~exp;

    cp0_timer u_timer (
        .clk_i        (clk),
        .reset_i      (reset),
        .count_we_i   (wr_en && (cp0_regw == CP0_COUNT)),
        .compare_we_i (wr_en && (cp0_regw == CP0_COMPARE)),
        .wdata_i      (cp0_wdata),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        // IP[7:2] track the interrupt lines every cycle, even while stalled.
        ip_d       = {ext_int[5] | ti, ext_int[4:0], ip_q[1:0]};
        if (wr_en) begin
            case (cp0_regw)
                CP0_STATUS: begin
                    im_d  = cp0_wdata[15:8];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                CP0_CAUSE: ip_d[1:0] = cp0_wdata[9:8];
                CP0_EPC:   epc_d     = cp0_wdata;
                default:   ;
            endcase
        end
        if (exc_en) begin
            // A nested exception keeps the original return address.
            if (!exl_q) begin
                epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
                bd_d  = exc_bd;
            end
            exc_code_d = excode;
            exl_d      = 1'b1;
            if (cp0_badwen) begin
                badvaddr_d = cp0_badvaddr;
            end
        end else if (eret_en) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        status_view     = '0;
        status_view.bev = 1'b1;
        status_view.im  = im_q;
        status_view.exl = exl_q;
        status_view.ie  = ie_q;

        cause_view          = '0;
        cause_view.bd       = bd_q;
        cause_view.ti       = ti;
        cause_view.ip       = ip_q;
        cause_view.exc_code = exc_code_q;
    end

    always_comb begin
        case (cp0_rreg)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = status_view;
            CP0_CAUSE:    cp0_rdata = cause_view;
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (!reset) begin
            if (exc_en) begin
                redirect    = 1'b1;
                redirect_pc = status_view.bev ? VEC_BEV1 : VEC_BEV0;
            end else if (eret_en) begin
                redirect    = 1'b1;
                redirect_pc = epc_q;
            end
        end
    end

    assign int_pending = ie_q & ~exl_q & |(ip_q & im_q);

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: register-access vector table plus hand-written
// exception, ERET, interrupt and timer sequences.
module tb_cp0;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset, commit_en, exp, exc_bd, cp0_badwen, cp0_wen, eret;
    logic [4:0]  excode, cp0_regw, cp0_rreg;
    logic [31:0] exc_pc, cp0_badvaddr, cp0_wdata, cp0_rdata, redirect_pc;
    logic [5:0]  ext_int;
    logic        int_pending, redirect;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [4:0]  idx;
        logic [31:0] val;
        logic [31:0] mask;
    } rd_exp_t;
    rd_exp_t sbq[$];

    typedef struct {
        string       name;
        logic [4:0]  idx;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    cp0 dut (
        .clk          (clk),
        .reset        (reset),
        .commit_en    (commit_en),
        .exp          (exp),
        .excode       (excode),
        .exc_pc       (exc_pc),
        .exc_bd       (exc_bd),
        .cp0_badwen   (cp0_badwen),
        .cp0_badvaddr (cp0_badvaddr),
        .cp0_wen      (cp0_wen),
        .cp0_regw     (cp0_regw),
        .cp0_wdata    (cp0_wdata),
        .eret         (eret),
        .ext_int      (ext_int),
        .cp0_rreg     (cp0_rreg),
        .cp0_rdata    (cp0_rdata),
        .int_pending  (int_pending),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [4:0] idx, input logic [31:0] val,
                        input logic [31:0] mask);
        rd_exp_t e;
        e.name = name;
        e.idx  = idx;
        e.val  = val;
        e.mask = mask;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        rd_exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            cp0_rreg = e.idx;
            #1;
            chk(e.name, cp0_rdata & e.mask, e.val & e.mask);
        end
    endtask

    task automatic rd(input string name, input logic [4:0] idx, input logic [31:0] val,
                      input logic [31:0] mask);
        push(name, idx, val, mask);
        pop_check();
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] d);
        cp0_wen   = 1'b1;
        cp0_regw  = idx;
        cp0_wdata = d;
        cycle();
        cp0_wen   = 1'b0;
    endtask

    initial begin
        bit fired;
        reset = 1'b1; commit_en = 1'b1; exp = 1'b1; excode = ExcInt; exc_pc = '0;
        exc_bd = 1'b0; cp0_badwen = 1'b0; cp0_badvaddr = '0; cp0_wen = 1'b0;
        cp0_regw = '0; cp0_wdata = '0; eret = 1'b0; ext_int = '0; cp0_rreg = '0;
        repeat (3) cycle();
        chk("redirect_in_reset", {31'b0, redirect}, 32'd0);
        chk("int_pending_reset", {31'b0, int_pending}, 32'd0);
        exp   = 1'b0;
        reset = 1'b0;

        rd("status_reset", CP0_STATUS, 32'h0040_0000, '1);
        rd("cause_reset", CP0_CAUSE, 32'h0, '1);
        rd("epc_reset", CP0_EPC, 32'h0, '1);
        repeat (10) cycle();
        rd("count_after_10", CP0_COUNT, 32'd5, '1);
        // Count==Compare==0 out of reset raises TI.
        rd("cause_ti_after_reset", CP0_CAUSE, 32'h4000_0000, 32'h4000_0000);

        tbl[0] = '{"compare_rw", CP0_COMPARE, 32'hFFFF_0000, 32'hFFFF_0000};
        tbl[1] = '{"cause_mask", CP0_CAUSE, 32'hFFFF_FFFF, 32'h0000_0300};
        tbl[2] = '{"cause_clear", CP0_CAUSE, 32'h0, 32'h0};
        tbl[3] = '{"status_mask", CP0_STATUS, 32'hFFFF_FFFF, 32'h0040_FF03};
        tbl[4] = '{"status_clear", CP0_STATUS, 32'h0, 32'h0040_0000};
        tbl[5] = '{"epc_rw", CP0_EPC, 32'h1234_5678, 32'h1234_5678};
        tbl[6] = '{"badvaddr_ro", CP0_BADVADDR, 32'hFFFF_FFFF, 32'h0};
        tbl[7] = '{"unimpl_reg", 5'd3, 32'hFFFF_FFFF, 32'h0};
        tbl[8] = '{"epc_zero", CP0_EPC, 32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            push(tbl[i].name, tbl[i].idx, tbl[i].rexp, '1);
            mtc0(tbl[i].idx, tbl[i].wdata);
            pop_check();
        end

        // A Count write replaces that cycle's increment; the next tick may already follow.
        mtc0(CP0_COUNT, 32'h100);
        rd("count_write", CP0_COUNT, 32'h100, 32'hFFFF_FFFE);

        exp = 1'b1; excode = ExcAdel; exc_pc = 32'hBFC0_0104; exc_bd = 1'b1;
        cp0_badwen = 1'b1; cp0_badvaddr = 32'h1001;
        #1;
        chk("exc_redirect", {31'b0, redirect}, 32'd1);
        chk("exc_vector", redirect_pc, 32'hBFC0_0380);
        cycle();
        exp = 1'b0; cp0_badwen = 1'b0; exc_bd = 1'b0;
        rd("exc_epc", CP0_EPC, 32'hBFC0_0100, '1);
        rd("exc_cause", CP0_CAUSE, 32'h8000_0010, '1);
        rd("exc_badvaddr", CP0_BADVADDR, 32'h1001, '1);
        rd("exc_status", CP0_STATUS, 32'h0040_0002, '1);

        exp = 1'b1; excode = ExcOv; exc_pc = 32'h200;
        #1;
        chk("nested_redirect", {31'b0, redirect}, 32'd1);
        cycle();
        exp = 1'b0;
        rd("nested_epc", CP0_EPC, 32'hBFC0_0100, '1);
        rd("nested_cause", CP0_CAUSE, 32'h8000_0030, '1);

        eret = 1'b1;
        #1;
        chk("eret_redirect", {31'b0, redirect}, 32'd1);
        chk("eret_pc", redirect_pc, 32'hBFC0_0100);
        cycle();
        eret = 1'b0;
        rd("eret_status", CP0_STATUS, 32'h0040_0000, '1);

        cp0_wen = 1'b1; cp0_regw = CP0_STATUS; cp0_wdata = 32'h0000_8001; ext_int = 6'b100000;
        #1;
        chk("int_pending_lag", {31'b0, int_pending}, 32'd0);
        cycle();
        cp0_wen = 1'b0;
        chk("int_pending_ext", {31'b0, int_pending}, 32'd1);
        ext_int = '0;
        mtc0(CP0_STATUS, 32'h0000_8000);
        chk("int_pending_no_ie", {31'b0, int_pending}, 32'd0);

        mtc0(CP0_STATUS, 32'h0000_8001);
        mtc0(CP0_COMPARE, 32'd6);
        mtc0(CP0_COUNT, 32'd0);
        fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) begin
            if (int_pending) fired = 1'b1;
            else cycle();
        end
        chk("timer_int_fired", {31'b0, fired}, 32'd1);
        rd("timer_count", CP0_COUNT, 32'd6, 32'hFFFF_FFFE);
        rd("timer_ti_set", CP0_CAUSE, 32'h4000_8000, 32'h4000_8000);
        mtc0(CP0_COMPARE, 32'd100);
        rd("timer_ti_clear", CP0_CAUSE, 32'h0, 32'h4000_0000);

        exp = 1'b1; eret = 1'b1; excode = ExcAdes; exc_pc = 32'h300; exc_bd = 1'b0;
        cp0_wen = 1'b1; cp0_regw = CP0_EPC; cp0_wdata = 32'hDEAD_BEEF;
        #1;
        chk("exp_over_eret_pc", redirect_pc, 32'hBFC0_0380);
        cycle();
        exp = 1'b0; eret = 1'b0; cp0_wen = 1'b0;
        rd("exp_over_wen_epc", CP0_EPC, 32'h300, '1);
        rd("exp_over_wen_code", CP0_CAUSE, 32'h14, 32'h7C);
        rd("exp_over_wen_status", CP0_STATUS, 32'h0040_8003, '1);

        commit_en = 1'b0; exp = 1'b1; excode = ExcOv; exc_pc = 32'h400;
        cp0_badwen = 1'b1; cp0_badvaddr = 32'h5555;
        #1;
        chk("stall_no_redirect", {31'b0, redirect}, 32'd0);
        cycle();
        commit_en = 1'b1; exp = 1'b0; cp0_badwen = 1'b0;
        rd("stall_epc", CP0_EPC, 32'h300, '1);
        rd("stall_code", CP0_CAUSE, 32'h14, 32'h7C);
        rd("stall_badvaddr", CP0_BADVADDR, 32'h1001, '1);

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rd("midreset_epc", CP0_EPC, 32'h0, '1);
        rd("midreset_status", CP0_STATUS, 32'h0040_0000, '1);
        rd("midreset_compare", CP0_COMPARE, 32'h0, '1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
